// File: rtl/bus_pkg.sv
// Shared constants, FSM state types and geometry helpers for the CPU-to-SRAM/peripheral bridge.
package bus_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [11:0] SRAM_REGION_DEF = 12'h001;
    localparam logic [11:0] PERIPH_BASE_DEF = 12'h010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRAM,
        ST_PWAIT,
        ST_RESP,
        ST_ERR
    } bridge_state_e;

    typedef enum logic [1:0] {
        SR_IDLE,
        SR_SETUP,
        SR_STROBE
    } sram_state_e;

    function automatic int calc_beats(input int dw, input int sdw);
        return dw / sdw;
    endfunction

    function automatic int calc_bb(input int dw, input int sdw);
        return $clog2(dw / sdw);
    endfunction

endpackage

// File: rtl/sram_narrow_if.sv
// Splits one wide access into narrow SRAM beats (low half first), skipping write beats with no lanes.
// state     | meaning
// SR_IDLE   | strobes released, waiting for start
// SR_SETUP  | address/lanes/data driven, no write strobe yet
// SR_STROBE | we_n low for writes; read lane captured at the end of the cycle
module sram_narrow_if
    import bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRAM_DW = 16,
    parameter int SRAM_AW = 19
) (
    input  logic                  sck,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  start_rw_i,
    input  logic [DATA_W/8-1:0]   start_sel_i,
    input  logic                  rw_i,
    input  logic [DATA_W/8-1:0]   sel_i,
    input  logic [SRAM_AW-1:0]    base_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    output logic [SRAM_DW-1:0]    sram_wdata_o,
    input  logic [SRAM_DW-1:0]    sram_rdata_i,
    output logic                  sram_data_oe_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [SRAM_DW/8-1:0]  sram_be_n_o
);

    localparam int BEATS = calc_beats(DATA_W, SRAM_DW);
    localparam int BB    = calc_bb(DATA_W, SRAM_DW);
    localparam int BBW   = (BB > 0) ? BB : 1;
    localparam int LANES = SRAM_DW / 8;

    sram_state_e          state_q, state_d;
    logic [BBW-1:0]       beat_q, beat_d;
    logic [DATA_W-1:0]    rdata_q;
    logic [BBW:0]         nxt;
    logic [LANES-1:0]     lanes;
    logic [SRAM_DW-1:0]   wslice;
    logic                 active;

    // Returns {found, beat}: first beat at or after 'from' that has work to do.
    function automatic logic [BBW:0] first_active(input int from, input logic rw,
                                                  input logic [DATA_W/8-1:0] sel);
        logic           found;
        logic [BBW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (!found && b >= from && (rw == RW_READ || |sel[b*LANES +: LANES])) begin
                found = 1'b1;
                idx   = BBW'(b);
            end
        end
        return {found, idx};
    endfunction

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SR_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_o  = 1'b0;
        nxt     = '0;
        case (state_q)
            SR_IDLE: begin
                if (start_i) begin
                    nxt = first_active(0, start_rw_i, start_sel_i);
                    if (nxt[BBW]) begin
                        state_d = SR_SETUP;
                        beat_d  = nxt[BBW-1:0];
                    end else begin
                        done_o = 1'b1;
                    end
                end
            end
            SR_SETUP: state_d = SR_STROBE;
            SR_STROBE: begin
                nxt = first_active(int'(beat_q) + 1, rw_i, sel_i);
                if (nxt[BBW]) begin
                    state_d = SR_SETUP;
                    beat_d  = nxt[BBW-1:0];
                end else begin
                    state_d = SR_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = SR_IDLE;
        endcase
    end

    always_comb begin
        lanes  = '0;
        wslice = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BBW'(b)) begin
                lanes  = sel_i[b*LANES +: LANES];
                wslice = wdata_i[b*SRAM_DW +: SRAM_DW];
            end
        end
        active         = (state_q == SR_SETUP) || (state_q == SR_STROBE);
        sram_addr_o    = base_i | SRAM_AW'(beat_q);
        sram_wdata_o   = wslice;
        sram_ce_n_o    = !active;
        sram_oe_n_o    = !(active && rw_i == RW_READ);
        sram_data_oe_o = active && rw_i == RW_WRITE;
        sram_we_n_o    = !(state_q == SR_STROBE && rw_i == RW_WRITE);
        sram_be_n_o    = !active ? '1 : ((rw_i == RW_READ) ? '0 : ~lanes);
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state_q == SR_IDLE && start_i) begin
            rdata_q <= '0;
        end else if (state_q == SR_STROBE && rw_i == RW_READ) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == BBW'(b)) rdata_q[b*SRAM_DW +: SRAM_DW] <= sram_rdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_bridge.sv
// Single-master bridge: decodes addr[31:20] to narrow SRAM, peripheral channels or an error reply.
// state    | meaning
// ST_IDLE  | waiting for m_req_i; request registers load on acceptance
// ST_SRAM  | narrow SRAM beats in progress (sram_narrow_if)
// ST_PWAIT | selected channel strobed, waiting for its p_ready or timeout
// ST_RESP  | m_ready pulse with captured read data
// ST_ERR   | m_ready pulse with m_err (decode miss or timeout)
module bus_bridge
    import bus_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DW     = 16,
    parameter int          SRAM_AW     = 19,
    parameter int          NSLV        = 4,
    parameter logic [11:0] SRAM_REGION = SRAM_REGION_DEF,
    parameter logic [11:0] PERIPH_BASE = PERIPH_BASE_DEF,
    parameter int          TIMEOUT     = 255
) (
    input  logic                     sck,
    input  logic                     rst_n,
    input  logic                     m_req_i,
    input  logic                     m_rw_i,
    input  logic [DATA_W/8-1:0]      m_sel_i,
    input  logic [31:0]              m_addr_i,
    input  logic [DATA_W-1:0]        m_wdata_i,
    output logic [DATA_W-1:0]        m_rdata_o,
    output logic                     m_ready_o,
    output logic                     m_err_o,
    output logic [SRAM_AW-1:0]       sram_addr_o,
    output logic [SRAM_DW-1:0]       sram_wdata_o,
    input  logic [SRAM_DW-1:0]       sram_rdata_i,
    output logic                     sram_data_oe_o,
    output logic                     sram_ce_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_we_n_o,
    output logic [SRAM_DW/8-1:0]     sram_be_n_o,
    output logic [NSLV-1:0]          p_cs_n_o,
    output logic                     p_rw_o,
    output logic [DATA_W/8-1:0]      p_sel_o,
    output logic [31:0]              p_addr_o,
    output logic [DATA_W-1:0]        p_wdata_o,
    input  logic [NSLV*DATA_W-1:0]   p_rdata_i,
    input  logic [NSLV-1:0]          p_ready_i
);

    localparam int BB = calc_bb(DATA_W, SRAM_DW);
    localparam int TW = $clog2(TIMEOUT + 1);

    bridge_state_e       state_q, state_d;
    logic                rw_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          ch_q;
    logic                is_sram_q;
    logic [TW-1:0]       cnt_q;
    logic [DATA_W-1:0]   prd_q;

    logic [11:0]         region, off;
    logic                hit_sram, hit_periph, accept;
    logic                ch_ready;
    logic [DATA_W-1:0]   ch_rdata;
    logic                sram_done;
    logic [DATA_W-1:0]   sram_rdata_w;
    logic [SRAM_AW-1:0]  sram_base;

    assign region     = m_addr_i[31:20];
    assign off        = region - PERIPH_BASE;
    assign hit_sram   = (region == SRAM_REGION);
    assign hit_periph = (region >= PERIPH_BASE) && (off < 12'(NSLV));
    assign accept     = (state_q == ST_IDLE) && m_req_i;

    // Word address above the beat index; the beat number fills the low BB bits.
    assign sram_base = SRAM_AW'(addr_q >> 2) << BB;

    always_comb begin
        ch_ready = 1'b0;
        ch_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (ch_q == 4'(k)) begin
                ch_ready = p_ready_i[k];
                ch_rdata = p_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    sram_narrow_if #(
        .DATA_W  (DATA_W),
        .SRAM_DW (SRAM_DW),
        .SRAM_AW (SRAM_AW)
    ) u_sram (
        .sck            (sck),
        .rst_n          (rst_n),
        .start_i        (accept && hit_sram),
        .start_rw_i     (m_rw_i),
        .start_sel_i    (m_sel_i),
        .rw_i           (rw_q),
        .sel_i          (sel_q),
        .base_i         (sram_base),
        .wdata_i        (wdata_q),
        .done_o         (sram_done),
        .rdata_o        (sram_rdata_w),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_rdata_i   (sram_rdata_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
    );

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_req_i) begin
                    if (hit_sram)        state_d = sram_done ? ST_RESP : ST_SRAM;
                    else if (hit_periph) state_d = ST_PWAIT;
                    else                 state_d = ST_ERR;
                end
            end
            ST_SRAM:  if (sram_done) state_d = ST_RESP;
            ST_PWAIT: begin
                if (ch_ready)          state_d = ST_RESP;
                else if (cnt_q == '0)  state_d = ST_ERR;
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ready_o = (state_q == ST_RESP) || (state_q == ST_ERR);
        m_err_o   = (state_q == ST_ERR);
        m_rdata_o = '0;
        if (state_q == ST_RESP && rw_q == RW_READ)
            m_rdata_o = is_sram_q ? sram_rdata_w : prd_q;
        p_cs_n_o = '1;
        for (int k = 0; k < NSLV; k++) begin
            if (state_q == ST_PWAIT && ch_q == 4'(k)) p_cs_n_o[k] = 1'b0;
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= RW_READ;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ch_q      <= '0;
            is_sram_q <= 1'b0;
            cnt_q     <= '0;
            prd_q     <= '0;
        end else if (accept) begin
            rw_q      <= m_rw_i;
            sel_q     <= m_sel_i;
            addr_q    <= m_addr_i;
            wdata_q   <= m_wdata_i;
            ch_q      <= off[3:0];
            is_sram_q <= hit_sram;
            cnt_q     <= TW'(TIMEOUT - 1);
            prd_q     <= '0;
        end else if (state_q == ST_PWAIT) begin
            if (ch_ready)          prd_q <= ch_rdata;
            else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
        end
    end

    assign p_rw_o    = rw_q;
    assign p_sel_o   = sel_q;
    assign p_addr_o  = addr_q;
    assign p_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Bench for bus_bridge: behavioural SRAM and peripheral responders, word-level reference memory.
module tb_bus_bridge;

    localparam int NS = 4;
    localparam int TO = 8;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_req, m_rw;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ready, m_err;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  sram_be_n;
    logic [NS-1:0]    p_cs_n, p_ready;
    logic             p_rw;
    logic [3:0]       p_sel;
    logic [31:0]      p_addr, p_wdata;
    logic [NS*32-1:0] p_rdata;

    bus_bridge #(.NSLV(NS), .TIMEOUT(TO)) dut (
        .sck(sck), .rst_n(rst_n),
        .m_req_i(m_req), .m_rw_i(m_rw), .m_sel_i(m_sel), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata), .m_ready_o(m_ready), .m_err_o(m_err),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .sram_data_oe_o(sram_data_oe), .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n),
        .sram_we_n_o(sram_we_n), .sram_be_n_o(sram_be_n),
        .p_cs_n_o(p_cs_n), .p_rw_o(p_rw), .p_sel_o(p_sel), .p_addr_o(p_addr), .p_wdata_o(p_wdata),
        .p_rdata_i(p_rdata), .p_ready_i(p_ready)
    );

    always #5 sck = ~sck;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] smem [0:1023];
    logic [31:0] ref_mem [0:511];
    int          wr_cnt, ce_cnt, cs_cnt;
    logic [18:0] wq_addr [$];
    logic [15:0] wq_data [$];
    logic [1:0]  wq_be [$];
    logic [3:0]  cs_pat;
    logic [31:0] pa_seen, pw_seen;
    logic [3:0]  ps_seen;
    logic        prw_seen;
    int          dly [NS];
    int          csc [NS];
    bit          noise_en;
    logic        ready_after;

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? smem[sram_addr[9:0]] : 16'h0000;

    // Device models sampled mid-cycle, away from the active edge.
    always @(negedge sck) begin
        if (rst_n) begin
            if (!sram_ce_n) ce_cnt++;
            if (!sram_we_n) begin
                wr_cnt++;
                wq_addr.push_back(sram_addr);
                wq_data.push_back(sram_wdata);
                wq_be.push_back(sram_be_n);
                if (!sram_be_n[0]) smem[sram_addr[9:0]][7:0]  = sram_wdata[7:0];
                if (!sram_be_n[1]) smem[sram_addr[9:0]][15:8] = sram_wdata[15:8];
            end
            if (p_cs_n != 4'hF) begin
                cs_cnt++;
                cs_pat   = p_cs_n;
                pa_seen  = p_addr;
                pw_seen  = p_wdata;
                ps_seen  = p_sel;
                prw_seen = p_rw;
            end
        end
        for (int k = 0; k < NS; k++) begin
            if (!p_cs_n[k]) csc[k]++;
            else            csc[k] = 0;
            if (!p_cs_n[k]) p_ready[k] = (csc[k] == dly[k] + 1);
            else            p_ready[k] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic access(input logic rw, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        @(negedge sck);
        wr_cnt = 0; ce_cnt = 0; cs_cnt = 0; cs_pat = 4'hF;
        wq_addr.delete(); wq_data.delete(); wq_be.delete();
        m_req = 1'b1; m_rw = rw; m_addr = addr; m_sel = sel; m_wdata = wd;
        lat = 0; rd = 32'hxxxx_xxxx; err = 1'bx;
        for (int i = 1; i <= 200; i++) begin
            @(posedge sck); #1;
            if (m_ready) begin
                lat = i; rd = m_rdata; err = m_err;
                break;
            end
        end
        m_req = 1'b0;
        @(posedge sck); #1;
        ready_after = m_ready;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) if (sel[j]) r[j*8 +: 8] = d[j*8 +: 8];
        return r;
    endfunction

    task automatic test_reset();
        #12;
        n_tests++; if (m_ready !== 1'b0)      begin n_fail++; $display("FAIL rst_m_ready got %b exp 0", m_ready); end
        n_tests++; if (m_err !== 1'b0)        begin n_fail++; $display("FAIL rst_m_err got %b exp 0", m_err); end
        n_tests++; if (m_rdata !== 32'h0)     begin n_fail++; $display("FAIL rst_m_rdata got %h exp 0", m_rdata); end
        n_tests++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111)
                                              begin n_fail++; $display("FAIL rst_strobes got %b exp 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
        n_tests++; if (sram_be_n !== 2'b11)   begin n_fail++; $display("FAIL rst_be_n got %b exp 11", sram_be_n); end
        n_tests++; if (sram_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe got %b exp 0", sram_data_oe); end
        n_tests++; if (p_cs_n !== 4'hF)       begin n_fail++; $display("FAIL rst_p_cs_n got %b exp 1111", p_cs_n); end
        @(negedge sck); rst_n = 1'b1;
        @(posedge sck);
    endtask

    task automatic test_sram_write();
        logic [31:0] rd; logic err; int lat;
        access(1'b1, 32'h0010_0008, 4'hF, 32'hDEAD_BEEF, rd, err, lat);
        ref_mem[2] = 32'hDEAD_BEEF;
        n_tests++; if (lat != 5)      begin n_fail++; $display("FAIL wr_latency got %0d exp 5", lat); end
        n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL wr_err got %b exp 0", err); end
        n_tests++; if (wr_cnt != 2)   begin n_fail++; $display("FAIL wr_pulses got %0d exp 2", wr_cnt); end
        n_tests++; if (ready_after !== 1'b0) begin n_fail++; $display("FAIL wr_ready_pulse got %b exp 0", ready_after); end
        if (wq_addr.size() >= 2) begin
            n_tests++; if (wq_addr[0] !== 19'h00004) begin n_fail++; $display("FAIL wr_addr0 got %h exp 00004", wq_addr[0]); end
            n_tests++; if (wq_data[0] !== 16'hBEEF)  begin n_fail++; $display("FAIL wr_data0 got %h exp beef", wq_data[0]); end
            n_tests++; if (wq_be[0] !== 2'b00)       begin n_fail++; $display("FAIL wr_be0 got %b exp 00", wq_be[0]); end
            n_tests++; if (wq_addr[1] !== 19'h00005) begin n_fail++; $display("FAIL wr_addr1 got %h exp 00005", wq_addr[1]); end
            n_tests++; if (wq_data[1] !== 16'hDEAD)  begin n_fail++; $display("FAIL wr_data1 got %h exp dead", wq_data[1]); end
        end
    endtask

    task automatic test_sram_read();
        logic [31:0] rd; logic err; int lat;
        access(1'b0, 32'h0010_0008, 4'hF, 32'h0, rd, err, lat);
        n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef", rd); end
        n_tests++; if (lat != 5)     begin n_fail++; $display("FAIL rd_latency got %0d exp 5", lat); end
        n_tests++; if (wr_cnt != 0)  begin n_fail++; $display("FAIL rd_we_pulses got %0d exp 0", wr_cnt); end
        n_tests++; if (ce_cnt != 4)  begin n_fail++; $display("FAIL rd_ce_cycles got %0d exp 4", ce_cnt); end
    endtask

    task automatic test_lane_skip();
        logic [31:0] rd; logic err; int lat;
        access(1'b1, 32'h0010_0008, 4'b1100, 32'h1234_0000, rd, err, lat);
        ref_mem[2] = merge(ref_mem[2], 32'h1234_0000, 4'b1100);
        n_tests++; if (lat != 3)    begin n_fail++; $display("FAIL skip_latency got %0d exp 3", lat); end
        n_tests++; if (wr_cnt != 1) begin n_fail++; $display("FAIL skip_pulses got %0d exp 1", wr_cnt); end
        if (wq_addr.size() >= 1) begin
            n_tests++; if (wq_addr[0] !== 19'h00005) begin n_fail++; $display("FAIL skip_addr got %h exp 00005", wq_addr[0]); end
            n_tests++; if (wq_be[0] !== 2'b00)       begin n_fail++; $display("FAIL skip_be got %b exp 00", wq_be[0]); end
            n_tests++; if (wq_data[0] !== 16'h1234)  begin n_fail++; $display("FAIL skip_data got %h exp 1234", wq_data[0]); end
        end
        access(1'b1, 32'h0010_000C, 4'b0000, 32'hFFFF_FFFF, rd, err, lat);
        n_tests++; if (lat != 1)    begin n_fail++; $display("FAIL zsel_latency got %0d exp 1", lat); end
        n_tests++; if (ce_cnt != 0) begin n_fail++; $display("FAIL zsel_ce got %0d exp 0", ce_cnt); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL zsel_err got %b exp 0", err); end
    endtask

    task automatic test_sram_random();
        logic [31:0] rd, d; logic err; logic rw; logic [3:0] sel; int lat, w, nb;
        for (int it = 0; it < 40; it++) begin
            w   = $urandom_range(0, 255);
            rw  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            d   = $urandom;
            access(rw, 32'h0010_0000 | (w << 2), sel, d, rd, err, lat);
            if (rw) begin
                nb = int'(|sel[1:0]) + int'(|sel[3:2]);
                ref_mem[w] = merge(ref_mem[w], d, sel);
                n_tests++; if (lat != 1 + 2*nb) begin n_fail++; $display("FAIL rnd_wr_latency w=%0d sel=%b got %0d exp %0d", w, sel, lat, 1 + 2*nb); end
                n_tests++; if (wr_cnt != nb)    begin n_fail++; $display("FAIL rnd_wr_pulses w=%0d got %0d exp %0d", w, wr_cnt, nb); end
            end else begin
                n_tests++; if (rd !== ref_mem[w]) begin n_fail++; $display("FAIL rnd_rd_data w=%0d got %h exp %h", w, rd, ref_mem[w]); end
                n_tests++; if (lat != 5)          begin n_fail++; $display("FAIL rnd_rd_latency got %0d exp 5", lat); end
            end
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_sram_err got %b exp 0", err); end
        end
    endtask

    task automatic test_periph();
        logic [31:0] rd; logic err; int lat;
        for (int k = 0; k < NS; k++) p_rdata[k*32 +: 32] = $urandom;
        p_rdata[2*32 +: 32] = 32'hA5A5_0001;
        dly[2] = 3;
        access(1'b0, 32'h0120_0000, 4'hF, 32'h0, rd, err, lat);
        n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL per_data got %h exp a5a50001", rd); end
        n_tests++; if (lat != 5)        begin n_fail++; $display("FAIL per_latency got %0d exp 5", lat); end
        n_tests++; if (cs_cnt != 4)     begin n_fail++; $display("FAIL per_cs_cycles got %0d exp 4", cs_cnt); end
        n_tests++; if (cs_pat !== 4'b1011) begin n_fail++; $display("FAIL per_cs_pat got %b exp 1011", cs_pat); end
        n_tests++; if (pa_seen !== 32'h0120_0000) begin n_fail++; $display("FAIL per_addr got %h exp 01200000", pa_seen); end
        n_tests++; if (p_cs_n !== 4'hF) begin n_fail++; $display("FAIL per_cs_release got %b exp 1111", p_cs_n); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic err; int lat;
        dly[1] = -1;
        access(1'b1, 32'h0110_0040, 4'hF, 32'h1111_2222, rd, err, lat);
        n_tests++; if (err !== 1'b1)  begin n_fail++; $display("FAIL to_err got %b exp 1", err); end
        n_tests++; if (lat != TO + 1) begin n_fail++; $display("FAIL to_latency got %0d exp %0d", lat, TO + 1); end
        n_tests++; if (cs_cnt != TO)  begin n_fail++; $display("FAIL to_cs_cycles got %0d exp %0d", cs_cnt, TO); end
        n_tests++; if (rd !== 32'h0)  begin n_fail++; $display("FAIL to_rdata got %h exp 0", rd); end
        n_tests++; if (p_cs_n !== 4'hF) begin n_fail++; $display("FAIL to_cs_release got %b exp 1111", p_cs_n); end
        dly[1] = TO - 1;
        access(1'b0, 32'h0110_0040, 4'hF, 32'h0, rd, err, lat);
        n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL to_last_err got %b exp 0", err); end
        n_tests++; if (lat != TO + 1) begin n_fail++; $display("FAIL to_last_latency got %0d exp %0d", lat, TO + 1); end
        n_tests++; if (rd !== p_rdata[32 +: 32]) begin n_fail++; $display("FAIL to_last_data got %h exp %h", rd, p_rdata[32 +: 32]); end
    endtask

    task automatic test_periph_random();
        logic [31:0] rd, d, exp_rd; logic err, rw; logic [3:0] sel; int lat, ch;
        noise_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < NS; k++) begin
                p_rdata[k*32 +: 32] = $urandom;
                dly[k] = $urandom_range(0, 6);
            end
            ch  = $urandom_range(0, NS - 1);
            rw  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            d   = $urandom;
            exp_rd = rw ? 32'h0 : p_rdata[ch*32 +: 32];
            access(rw, (32'h010 + ch) << 20 | 32'($urandom_range(0, 4095)) << 2, sel, d, rd, err, lat);
            n_tests++; if (rd !== exp_rd)       begin n_fail++; $display("FAIL prnd_data ch=%0d got %h exp %h", ch, rd, exp_rd); end
            n_tests++; if (lat != dly[ch] + 2)  begin n_fail++; $display("FAIL prnd_latency ch=%0d got %0d exp %0d", ch, lat, dly[ch] + 2); end
            n_tests++; if (cs_pat !== ~(4'b1 << ch)) begin n_fail++; $display("FAIL prnd_cs_pat got %b exp %b", cs_pat, ~(4'b1 << ch)); end
            n_tests++; if ({prw_seen, ps_seen, pw_seen} !== {rw, sel, d})
                begin n_fail++; $display("FAIL prnd_req_copy got %h exp %h", {prw_seen, ps_seen, pw_seen}, {rw, sel, d}); end
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL prnd_err got %b exp 0", err); end
        end
        noise_en = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic err; int lat;
        logic [31:0] bad [4];
        bad[0] = 32'h0800_0000; bad[1] = 32'h0140_0000; bad[2] = 32'h00F0_0010; bad[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            access(1'($urandom_range(0, 1)), bad[i], 4'hF, $urandom, rd, err, lat);
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unm_err addr=%h got %b exp 1", bad[i], err); end
            n_tests++; if (lat != 1)     begin n_fail++; $display("FAIL unm_latency addr=%h got %0d exp 1", bad[i], lat); end
            n_tests++; if (ce_cnt + cs_cnt != 0) begin n_fail++; $display("FAIL unm_strobes addr=%h got %0d exp 0", bad[i], ce_cnt + cs_cnt); end
            n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unm_rdata got %h exp 0", rd); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat; bit found, seen;
        found = 0; seen = 0;
        @(negedge sck);
        m_req = 1'b1; m_rw = 1'b1; m_addr = 32'h0010_04B0; m_sel = 4'hF; m_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sck);
            if (!sram_we_n) found = 1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL mid_strobe_seen got 0 exp 1"); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if ({sram_we_n, sram_ce_n, sram_data_oe} !== 3'b110)
            begin n_fail++; $display("FAIL mid_async_release got %b exp 110", {sram_we_n, sram_ce_n, sram_data_oe}); end
        m_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sck); #1;
            if (m_ready) seen = 1;
        end
        @(negedge sck); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sck); #1;
            if (m_ready) seen = 1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL mid_no_ready got 1 exp 0"); end
        access(1'b0, 32'h0010_0008, 4'hF, 32'h0, rd, err, lat);
        n_tests++; if (rd !== ref_mem[2]) begin n_fail++; $display("FAIL mid_recover got %h exp %h", rd, ref_mem[2]); end
    endtask

    initial begin
        m_req = 1'b0; m_rw = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        p_rdata = '0; p_ready = '0; noise_en = 1'b0; ready_after = 1'b0;
        wr_cnt = 0; ce_cnt = 0; cs_cnt = 0; cs_pat = 4'hF;
        pa_seen = '0; pw_seen = '0; ps_seen = '0; prw_seen = 1'b0;
        for (int k = 0; k < NS; k++) begin dly[k] = -1; csc[k] = 0; end
        for (int i = 0; i < 1024; i++) smem[i] = 16'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_sram_write();
        test_sram_read();
        test_lane_skip();
        test_sram_random();
        test_periph();
        test_timeout();
        test_periph_random();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
